// File: rtl/ecc_enc_pipe_if.sv
// ecc_enc_pipe_if: handshake and payload bundle for the SECDED encoder pipe.
//   valid_i/ready_o/d_i/inj_*_i : upstream beat (data + error-injection request)
//   valid_o/ready_i/q_o/inj_o   : downstream beat (codewords + injected flag)
//   inj_cnt_o                   : saturating count of accepted injected beats
// slave modport is used by the encoder; master modport is the driver's view.
interface ecc_enc_pipe_if #(
  parameter int unsigned K     = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
);
  // Parity bit count: smallest m with 2^m >= m+K+1.
  function automatic int unsigned calc_m(input int unsigned k);
    for (int unsigned m = 1; m < 31; m++) begin
      if ((32'(1) << m) >= m + k + 1) return m;
    end
    return 31;
  endfunction

  localparam int unsigned M  = calc_m(K);
  localparam int unsigned W  = M + K + 1;
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PW = $clog2(W);

  logic                   valid_i;
  logic                   ready_o;
  logic [LANES*K-1:0]     d_i;
  logic [1:0]             inj_mode_i;
  logic [LW-1:0]          inj_lane_i;
  logic [PW-1:0]          inj_pos_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [LANES*W-1:0]     q_o;
  logic                   inj_o;
  logic [CNT_W-1:0]       inj_cnt_o;

  modport slave (
    input  valid_i, d_i, inj_mode_i, inj_lane_i, inj_pos_i, ready_i,
    output ready_o, valid_o, q_o, inj_o, inj_cnt_o
  );

  modport master (
    output valid_i, d_i, inj_mode_i, inj_lane_i, inj_pos_i, ready_i,
    input  ready_o, valid_o, q_o, inj_o, inj_cnt_o
  );
endinterface

// File: rtl/ecc_enc_pipe.sv
// ecc_enc_pipe: multi-lane extended-Hamming (SECDED) encoder with an elastic
// 1- or 2-stage valid/ready pipeline, per-beat single/double bit-flip
// injection on one lane, and a saturating injected-beat counter.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : ecc_enc_pipe_if.slave (handshake, data, injection, codewords)
module ecc_enc_pipe #(
  parameter int unsigned K      = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned P0_LSB = 1,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ecc_enc_pipe_if.slave bus
);

  function automatic int unsigned calc_m(input int unsigned k);
    for (int unsigned m = 1; m < 31; m++) begin
      if ((32'(1) << m) >= m + k + 1) return m;
    end
    return 31;
  endfunction

  localparam int unsigned M  = calc_m(K);
  localparam int unsigned N  = M + K;
  localparam int unsigned W  = N + 1;
  localparam int unsigned PW = $clog2(W);
  localparam int unsigned QW = LANES * W;

  // Hamming positions 1..N: data fills non-powers of two, parity at 2^j.
  function automatic logic [W-1:0] encode(input logic [K-1:0] d);
    logic [N:0]   cw;
    logic [K-1:0] dd;
    logic         p;
    cw = '0;
    dd = d;
    p  = 1'b0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = dd[0];
        dd      = dd >> 1;
      end
    end
    for (int unsigned j = 0; j < M; j++) begin
      p = 1'b0;
      for (int unsigned pos = 1; pos <= N; pos++) begin
        if (((pos >> j) & 1) != 0 && (pos & (pos - 1)) != 0) p = p ^ cw[pos];
      end
      cw[32'(1) << j] = p;
    end
    cw[0] = ^cw[N:1];
    if (P0_LSB != 0) return cw;
    return {cw[0], cw[N:1]};
  endfunction

  logic [QW-1:0]  w_q;
  logic [W-1:0]   w_cw;
  logic           w_inj;
  logic [PW-1:0]  w_p1;
  logic [PW-1:0]  w_p2;
  logic           w_rdy1;
  logic           w_rdy2;
  logic           w_acc;

  logic           r_v1;
  logic           r_inj1;
  logic [QW-1:0]  r_q1;
  logic [CNT_W-1:0] r_cnt;

  // Encode all lanes, then flip the requested bit(s) of the selected lane.
  always_comb begin
    w_q   = '0;
    w_cw  = '0;
    w_inj = (bus.inj_mode_i == 2'b01) || (bus.inj_mode_i == 2'b10);
    w_p1  = PW'(32'(bus.inj_pos_i) % W);
    w_p2  = (32'(w_p1) == W - 1) ? '0 : PW'(w_p1 + 1'b1);
    for (int unsigned l = 0; l < LANES; l++) begin
      w_cw = encode(bus.d_i[l*K +: K]);
      if (32'(bus.inj_lane_i) == l) begin
        if (bus.inj_mode_i == 2'b01) begin
          w_cw[w_p1] = ~w_cw[w_p1];
        end else if (bus.inj_mode_i == 2'b10) begin
          w_cw[w_p1] = ~w_cw[w_p1];
          w_cw[w_p2] = ~w_cw[w_p2];
        end
      end
      w_q[l*W +: W] = w_cw;
    end
  end

  // Stage 1 accepts when empty or when its contents move on this cycle.
  assign w_rdy1      = !r_v1 || w_rdy2;
  assign w_acc       = bus.valid_i && w_rdy1;
  assign bus.ready_o = w_rdy1;

  // Stage 1: codeword register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1   <= 1'b0;
      r_inj1 <= 1'b0;
      r_q1   <= '0;
    end else if (w_rdy1) begin
      r_v1 <= bus.valid_i;
      if (bus.valid_i) begin
        r_q1   <= w_q;
        r_inj1 <= w_inj;
      end
    end
  end

  // Injected-beat counter, saturating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_acc && w_inj && (r_cnt != '1)) begin
      r_cnt <= CNT_W'(r_cnt + 1'b1);
    end
  end

  assign bus.inj_cnt_o = r_cnt;

  generate
    if (STAGES >= 2) begin : g_two
      logic          r_v2;
      logic          r_inj2;
      logic [QW-1:0] r_q2;

      assign w_rdy2 = !r_v2 || bus.ready_i;

      // Stage 2: output register.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_v2   <= 1'b0;
          r_inj2 <= 1'b0;
          r_q2   <= '0;
        end else if (w_rdy2) begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_q2   <= r_q1;
            r_inj2 <= r_inj1;
          end
        end
      end

      assign bus.valid_o = r_v2;
      assign bus.q_o     = r_q2;
      assign bus.inj_o   = r_inj2;
    end else begin : g_one
      assign w_rdy2      = bus.ready_i;
      assign bus.valid_o = r_v1;
      assign bus.q_o     = r_q1;
      assign bus.inj_o   = r_inj1;
    end
  endgenerate

endmodule

// File: tb/tb_ecc_enc_pipe.sv
// tb_ecc_enc_pipe: scoreboard bench for ecc_enc_pipe. DUT a uses the default
// configuration; DUT b (p0 at MSB, one stage, 2-bit counter) takes exactly the
// beats a accepts, with its output always ready.
module tb_ecc_enc_pipe;
  localparam int unsigned K     = 8;
  localparam int unsigned LANES = 2;
  localparam int unsigned W     = 13;
  localparam int unsigned QW    = LANES * W;

  typedef struct {
    logic [QW-1:0] q;
    logic          inj;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;
  int accepted = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   cnt_a_m = 0;
  int   cnt_b_m = 0;
  bit            prev_stall = 0;
  logic [QW-1:0] prev_q;
  logic          prev_inj;

  ecc_enc_pipe_if #(.K(K), .LANES(LANES), .CNT_W(16)) bus_a ();
  ecc_enc_pipe_if #(.K(K), .LANES(LANES), .CNT_W(2))  bus_b ();

  ecc_enc_pipe #(.K(K), .LANES(LANES), .P0_LSB(1), .STAGES(2), .CNT_W(16)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave));

  ecc_enc_pipe #(.K(K), .LANES(LANES), .P0_LSB(0), .STAGES(1), .CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave));

  assign bus_b.valid_i    = bus_a.valid_i & bus_a.ready_o;
  assign bus_b.d_i        = bus_a.d_i;
  assign bus_b.inj_mode_i = bus_a.inj_mode_i;
  assign bus_b.inj_lane_i = bus_a.inj_lane_i;
  assign bus_b.inj_pos_i  = bus_a.inj_pos_i;
  assign bus_b.ready_i    = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: data bits at fixed Hamming positions; parity = XOR of set positions.
  function automatic logic [W-1:0] model_cw(input logic [K-1:0] d, input bit p0_lsb);
    int unsigned dpos [K];
    logic [W-1:0] cw;
    int unsigned syn;
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
    cw   = '0;
    syn  = 0;
    for (int i = 0; i < K; i++) begin
      if (d[i]) begin
        cw[dpos[i]] = 1'b1;
        syn = syn ^ dpos[i];
      end
    end
    for (int j = 0; j < 4; j++) cw[1 << j] = ((syn >> j) & 1) != 0;
    cw[0] = ^cw[W-1:1];
    if (p0_lsb) return cw;
    return {cw[0], cw[W-1:1]};
  endfunction

  function automatic exp_t model_beat(input logic [QW-1:0] dummy, input logic [LANES*K-1:0] d,
                                      input logic [1:0] mode, input int lane, input int pos,
                                      input bit p0_lsb);
    exp_t e;
    logic [W-1:0] cw;
    int p1, p2;
    p1 = pos % W;
    p2 = (pos + 1) % W;
    e.q = dummy;
    for (int l = 0; l < LANES; l++) begin
      cw = model_cw(d[l*K +: K], p0_lsb);
      if (l == lane && mode == 2'b01) cw[p1] = ~cw[p1];
      if (l == lane && mode == 2'b10) begin
        cw[p1] = ~cw[p1];
        cw[p2] = ~cw[p2];
      end
      e.q[l*W +: W] = cw;
    end
    e.inj = (mode == 2'b01) || (mode == 2'b10);
    return e;
  endfunction

  // Monitor: counters, stall stability, scoreboard pop then push.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_a.delete();
      sb_b.delete();
      cnt_a_m    = 0;
      cnt_b_m    = 0;
      prev_stall = 0;
    end else begin
      check("cnt_a", 64'(bus_a.inj_cnt_o), 64'(cnt_a_m));
      check("cnt_b", 64'(bus_b.inj_cnt_o), 64'(cnt_b_m));
      if (prev_stall) begin
        check("stall_valid", 64'(bus_a.valid_o), 64'(1));
        check("stall_q", 64'(bus_a.q_o), 64'(prev_q));
        check("stall_inj", 64'(bus_a.inj_o), 64'(prev_inj));
      end
      if (bus_a.valid_o && bus_a.ready_i) begin
        if (sb_a.size() == 0) check("sb_a_empty", 64'(1), 64'(0));
        else begin
          e = sb_a.pop_front();
          check("sb_a_q", 64'(bus_a.q_o), 64'(e.q));
          check("sb_a_inj", 64'(bus_a.inj_o), 64'(e.inj));
        end
      end
      if (bus_b.valid_o) begin
        if (sb_b.size() == 0) check("sb_b_empty", 64'(1), 64'(0));
        else begin
          e = sb_b.pop_front();
          check("sb_b_q", 64'(bus_b.q_o), 64'(e.q));
          check("sb_b_inj", 64'(bus_b.inj_o), 64'(e.inj));
        end
      end
      if (bus_a.valid_i && bus_a.ready_o) begin
        sb_a.push_back(model_beat('0, bus_a.d_i, bus_a.inj_mode_i, int'(bus_a.inj_lane_i),
                                  int'(bus_a.inj_pos_i), 1'b1));
        sb_b.push_back(model_beat('0, bus_a.d_i, bus_a.inj_mode_i, int'(bus_a.inj_lane_i),
                                  int'(bus_a.inj_pos_i), 1'b0));
        if (bus_a.inj_mode_i == 2'b01 || bus_a.inj_mode_i == 2'b10) begin
          if (cnt_a_m < 65535) cnt_a_m++;
          if (cnt_b_m < 3) cnt_b_m++;
        end
        accepted++;
      end
      prev_stall = bus_a.valid_o && !bus_a.ready_i;
      prev_q     = bus_a.q_o;
      prev_inj   = bus_a.inj_o;
    end
  end

  task automatic set_in(input logic vld, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] mode, input logic lane, input logic [3:0] pos);
    bus_a.valid_i    = vld;
    bus_a.d_i        = {d1, d0};
    bus_a.inj_mode_i = mode;
    bus_a.inj_lane_i = lane;
    bus_a.inj_pos_i  = pos;
  endtask

  // One beat on an idle, unstalled pipe; checks latency and absolute codewords.
  task automatic directed(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [1:0] mode, input logic lane, input logic [3:0] pos,
                          input logic [12:0] ea0, input logic [12:0] ea1,
                          input logic [12:0] eb0, input logic [12:0] eb1, input logic einj);
    @(posedge clk); #1;
    bus_a.ready_i = 1'b1;
    set_in(1'b1, d0, d1, mode, lane, pos);
    @(posedge clk); #1;
    set_in(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0);
    check({tag, "_a_lat1"}, 64'(bus_a.valid_o), 64'(0));
    check({tag, "_b_v"}, 64'(bus_b.valid_o), 64'(1));
    check({tag, "_b_l0"}, 64'(bus_b.q_o[0 +: W]), 64'(eb0));
    check({tag, "_b_l1"}, 64'(bus_b.q_o[W +: W]), 64'(eb1));
    @(posedge clk); #1;
    check({tag, "_a_v"}, 64'(bus_a.valid_o), 64'(1));
    check({tag, "_a_l0"}, 64'(bus_a.q_o[0 +: W]), 64'(ea0));
    check({tag, "_a_l1"}, 64'(bus_a.q_o[W +: W]), 64'(ea1));
    check({tag, "_a_inj"}, 64'(bus_a.inj_o), 64'(einj));
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic push_beat(input logic [7:0] d0, input logic [7:0] d1);
    int guard;
    guard = 0;
    set_in(1'b1, d0, d1, 2'b01, 1'b0, 4'd3);
    @(negedge clk);
    while (!bus_a.ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("push_accept", 64'(bus_a.ready_o), 64'(1));
    @(posedge clk); #1;
    set_in(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int guard;
    rst_n         = 1'b0;
    bus_a.ready_i = 1'b1;
    set_in(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0);
    #23;
    check("rst_valid", 64'(bus_a.valid_o), 64'(0));
    check("rst_q", 64'(bus_a.q_o), 64'(0));
    check("rst_inj", 64'(bus_a.inj_o), 64'(0));
    check("rst_cnt", 64'(bus_a.inj_cnt_o), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(bus_a.ready_o), 64'(1));

    directed("enc", 8'h01, 8'hFF, 2'b00, 1'b0, 4'd0, 13'h000F, 13'h1EEE, 13'h1007, 13'h0F77, 1'b0);
    directed("s0", 8'h01, 8'hFF, 2'b01, 1'b0, 4'd0, 13'h000E, 13'h1EEE, 13'h1006, 13'h0F77, 1'b1);
    check("cnt1", 64'(bus_a.inj_cnt_o), 64'(1));
    directed("d12", 8'h01, 8'hFF, 2'b10, 1'b0, 4'd12, 13'h100E, 13'h1EEE, 13'h0006, 13'h0F77, 1'b1);
    directed("s15", 8'h01, 8'hFF, 2'b01, 1'b1, 4'd15, 13'h000F, 13'h1EEA, 13'h1007, 13'h0F73, 1'b1);
    directed("d13", 8'h01, 8'hFF, 2'b10, 1'b1, 4'd13, 13'h000F, 13'h1EED, 13'h1007, 13'h0F74, 1'b1);
    directed("rsv", 8'h01, 8'hFF, 2'b11, 1'b0, 4'd0, 13'h000F, 13'h1EEE, 13'h1007, 13'h0F77, 1'b0);
    directed("s5", 8'h01, 8'hFF, 2'b01, 1'b0, 4'd5, 13'h002F, 13'h1EEE, 13'h1027, 13'h0F77, 1'b1);
    check("cnt_a_5", 64'(bus_a.inj_cnt_o), 64'(5));
    check("cnt_b_sat", 64'(bus_b.inj_cnt_o), 64'(3));

    // Full-rate burst: ready_o never drops, valid_o continuous once filled.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      set_in(1'b1, 8'($urandom), 8'($urandom), 2'($urandom % 4), 1'($urandom % 2),
             4'($urandom % 16));
      #1;
      check("burst_ready", 64'(bus_a.ready_o), 64'(1));
      if (i >= 2) check("burst_valid", 64'(bus_a.valid_o), 64'(1));
    end

    // Random stream with downstream back-pressure.
    target = accepted + 100;
    guard  = 0;
    while (accepted < target && guard < 5000) begin
      @(posedge clk); #1;
      set_in(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 2'($urandom % 4),
             1'($urandom % 2), 4'($urandom % 16));
      bus_a.ready_i = ($urandom % 4) != 0;
      guard++;
    end
    check("stream_done", 64'(accepted >= target), 64'(1));

    @(posedge clk); #1;
    set_in(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0);
    bus_a.ready_i = 1'b1;
    guard = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 64'(sb_a.size() + sb_b.size()), 64'(0));

    // Reset with two beats stuck in a stalled pipe.
    @(posedge clk); #1;
    bus_a.ready_i = 1'b0;
    push_beat(8'hA5, 8'h3C);
    push_beat(8'h5A, 8'hC3);
    @(posedge clk); #1;
    check("pre_rst_full", 64'(bus_a.ready_o), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus_a.valid_o), 64'(0));
    check("mid_rst_cnt_a", 64'(bus_a.inj_cnt_o), 64'(0));
    check("mid_rst_cnt_b", 64'(bus_b.inj_cnt_o), 64'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus_a.ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", 64'(bus_a.valid_o), 64'(0));
      check("post_rst_ready", 64'(bus_a.ready_o), 64'(1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
